// File: rtl/router_sync_n.sv
// Router synchroniser for NUM_CH output FIFOs.
// Latches the header destination and steers the FSM write request to one FIFO.
// Returns that FIFO's full flag and drives per-channel valid outputs.
// A per-channel watchdog flushes any FIFO whose data sits unread for TIMEOUT cycles.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_addr,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_en_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_en,
  input  logic [NUM_CH-1:0] timeout_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_sticky
);

  logic [ADDR_W-1:0] fifo_addr;
  logic              addr_valid;
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_next [NUM_CH];
  logic [NUM_CH-1:0] pulse_next;

  // Header address latch; only a detect_addr strobe can change the selection
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_addr  <= '0;
      addr_valid <= 1'b1;
    end else if (detect_addr) begin
      fifo_addr  <= data_in;
      addr_valid <= ({1'b0, data_in} < (ADDR_W+1)'(NUM_CH));
    end
  end

  assign addr_err = ~addr_valid;
  assign vld_out  = ~empty;

  // One-hot write steering; full is deliberately not used here, the FSM gates on fifo_full
  always_comb begin
    write_enb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_valid && write_en_reg && (fifo_addr == ADDR_W'(i)))
        write_enb[i] = 1'b1;
    end
  end

  // Full flag of the selected FIFO; an illegal address reports not-full
  always_comb begin
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_valid && (fifo_addr == ADDR_W'(i)))
        fifo_full = full[i];
    end
  end

  // Watchdog next state: empty or read restarts the count, expiry wraps and requests a flush
  always_comb begin
    pulse_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_next[i] = cnt[i] + CNT_W'(1);
      if (empty[i] || read_en[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
        cnt_next[i]   = '0;
        pulse_next[i] = 1'b1;
      end
    end
  end

  // Watchdog counters and the one-cycle soft reset pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      soft_reset <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_next[i];
      soft_reset <= pulse_next;
    end
  end

  // Sticky timeout log; it rises together with the pulse and a coincident clear loses
  always_ff @(posedge clock) begin
    if (reset)
      timeout_sticky <= '0;
    else
      timeout_sticky <= (timeout_sticky & ~timeout_clr) | pulse_next | soft_reset;
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n with the default 3-channel configuration.
module tb_router_sync_n;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_addr;
  logic [1:0] data_in;
  logic       write_en_reg;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] read_en;
  logic [2:0] timeout_clr;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       addr_err;
  logic [2:0] timeout_sticky;

  int checks = 0;
  int errors = 0;

  router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .detect_addr(detect_addr),
    .data_in(data_in),
    .write_en_reg(write_en_reg),
    .full(full),
    .empty(empty),
    .read_en(read_en),
    .timeout_clr(timeout_clr),
    .write_enb(write_enb),
    .fifo_full(fifo_full),
    .vld_out(vld_out),
    .soft_reset(soft_reset),
    .addr_err(addr_err),
    .timeout_sticky(timeout_sticky)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    detect_addr = 1'b0;
    data_in = 2'd0;
    write_en_reg = 1'b0;
    full = 3'b000;
    empty = 3'b111;
    read_en = 3'b000;
    timeout_clr = 3'b000;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    full = 3'b001;
    #1;
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_soft_reset", 32'(soft_reset), 32'd0);
    check("rst_sticky", 32'(timeout_sticky), 32'd0);
    check("rst_write_enb", 32'(write_enb), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd1);
    check("rst_vld_out", 32'(vld_out), 32'd0);

    detect_addr = 1'b1;
    data_in = 2'd1;
    tick();
    detect_addr = 1'b0;
    write_en_reg = 1'b1;
    full = 3'b010;
    #1;
    check("addr1_write_enb", 32'(write_enb), 32'b010);
    check("addr1_fifo_full", 32'(fifo_full), 32'd1);
    write_en_reg = 1'b0;
    #1;
    check("addr1_wr_idle", 32'(write_enb), 32'b000);
    data_in = 2'd3;
    tick();
    check("hold_addr_write_enb", 32'(write_enb), 32'b000);
    write_en_reg = 1'b1;
    #1;
    check("hold_addr_sel", 32'(write_enb), 32'b010);

    detect_addr = 1'b1;
    data_in = 2'd3;
    tick();
    detect_addr = 1'b0;
    full = 3'b111;
    #1;
    check("bad_addr_err", 32'(addr_err), 32'd1);
    check("bad_write_enb", 32'(write_enb), 32'b000);
    check("bad_fifo_full", 32'(fifo_full), 32'd0);
    detect_addr = 1'b1;
    data_in = 2'd2;
    tick();
    detect_addr = 1'b0;
    full = 3'b100;
    #1;
    check("addr2_err", 32'(addr_err), 32'd0);
    check("addr2_write_enb", 32'(write_enb), 32'b100);
    check("addr2_fifo_full", 32'(fifo_full), 32'd1);
    write_en_reg = 1'b0;

    do_reset();
    empty = 3'b110;
    for (int e = 1; e <= 65; e++) begin
      tick();
      check("ch0_pulse", 32'(soft_reset), (e == 30 || e == 60) ? 32'b001 : 32'b000);
      check("ch0_sticky", 32'(timeout_sticky), (e >= 30) ? 32'b001 : 32'b000);
      check("ch0_vld", 32'(vld_out), 32'b001);
    end

    do_reset();
    empty = 3'b101;
    for (int e = 1; e <= 70; e++) begin
      read_en = (e == 29) ? 3'b010 : 3'b000;
      tick();
      check("ch1_read_restart", 32'(soft_reset), (e == 59) ? 32'b010 : 32'b000);
    end
    read_en = 3'b000;

    do_reset();
    for (int e = 1; e <= 60; e++) begin
      empty = (e == 21) ? 3'b111 : 3'b011;
      tick();
      check("ch2_empty_restart", 32'(soft_reset), (e == 51) ? 32'b100 : 32'b000);
    end

    do_reset();
    empty = 3'b011;
    for (int e = 1; e <= 40; e++) begin
      reset = (e == 25);
      tick();
      check("ch2_reset_mid", 32'(soft_reset), 32'b000);
    end
    reset = 1'b0;
    check("ch2_reset_sticky", 32'(timeout_sticky), 32'b000);

    do_reset();
    empty = 3'b000;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check("all_pulse", 32'(soft_reset), (e == 30) ? 32'b111 : 32'b000);
    end

    do_reset();
    empty = 3'b110;
    for (int e = 1; e <= 30; e++) tick();
    check("clr_pulse_seen", 32'(soft_reset), 32'b001);
    empty = 3'b111;
    timeout_clr = 3'b001;
    tick();
    check("clr_set_wins", 32'(timeout_sticky), 32'b001);
    check("clr_pulse_gone", 32'(soft_reset), 32'b000);
    tick();
    timeout_clr = 3'b000;
    check("clr_cleared", 32'(timeout_sticky), 32'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised successor to the 3-port router synchroniser. It latches the packet destination address and steers the write-enable to one of NUM_CH output FIFOs. It also muxes back that FIFO's full flag and drives per-channel valid outputs. It runs a per-channel read-idle watchdog that soft-resets any FIFO left unread for TIMEOUT cycles. New over the previous generation: channel count, address width and timeout are generic, destination addresses are range-checked, and timeout events are logged in sticky bits.

Parameters:
NUM_CH, 3, number of output channels/FIFOs; legal range 1..2**ADDR_W
ADDR_W, 2, destination address field width
TIMEOUT, 30, consecutive unread-valid cycles before soft reset; must be >= 2
CNT_W, 5, watchdog counter width; must satisfy 2**CNT_W >= TIMEOUT

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
detect_addr  in  1  header cycle strobe from the router FSM; latch data_in
data_in  in  ADDR_W  destination address field of the header byte
write_en_reg  in  1  FSM request to write the current byte
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
read_en  in  NUM_CH  per-FIFO read enables from the downstream clients
timeout_clr  in  NUM_CH  per-channel clear for timeout_sticky
write_enb  out  NUM_CH  one-hot FIFO write enable
fifo_full  out  1  full flag of the selected FIFO
vld_out  out  NUM_CH  per-channel data-valid to the clients
soft_reset  out  NUM_CH  one-cycle FIFO flush pulse per channel
addr_err  out  1  latched destination address is out of range
timeout_sticky  out  NUM_CH  records that a soft reset has occurred on the channel

Behaviour:
- Reset (reset=1 at an edge): fifo_addr=0, addr_valid=1, addr_err=0, all counters=0, soft_reset=0, timeout_sticky=0. Combinational outputs follow from these values.
- Address latch: on an edge with detect_addr=1, fifo_addr<=data_in and addr_valid<=(data_in<NUM_CH). Otherwise both hold. There is no other path that changes them.
- addr_err = ~addr_valid (registered). It rises the cycle after an out-of-range detect_addr and stays high until a detect_addr with a legal address.
- write_enb (combinational):
  - bit fifo_addr = write_en_reg & addr_valid; all other bits 0.
  - Never more than one bit high.
  - Not gated by full; the FSM uses fifo_full for that.
- fifo_full (combinational): full[fifo_addr] when addr_valid, else 0.
- vld_out[i] = ~empty[i] (combinational, zero latency).
- Watchdog, per channel i, evaluated at each edge in priority order:
  1. reset: cnt=0, soft_reset[i]=0.
  2. empty[i]=1: cnt=0, soft_reset[i]=0.
  3. read_en[i]=1: cnt=0, soft_reset[i]=0.
  4. cnt==TIMEOUT-1: cnt=0, soft_reset[i]=1.
  5. otherwise: cnt=cnt+1, soft_reset[i]=0.
- Watchdog timing:
  - soft_reset[i] is high for exactly one cycle, starting the cycle after the TIMEOUT-th consecutive valid-and-unread cycle.
  - If the stall persists, the next pulse follows TIMEOUT cycles later.
  - Any read or empty cycle restarts the count from 0.
- Differences from the previous generation: the counter clears on empty instead of holding, and soft_reset never holds high for more than one cycle.
- timeout_sticky[i]:
  - Set on any cycle where soft_reset[i]=1.
  - Cleared by timeout_clr[i]=1.
  - If set and clear coincide, set wins.
- Channels are fully independent; simultaneous timeouts on several channels all pulse in the same cycle.
- Reset mid-count discards progress with no pulse. detect_addr changes do not affect the watchdogs.

Test Plan:
1. Reset; detect_addr=1, data_in=1; then write_en_reg=1, full=3'b010 -> write_enb=3'b010, fifo_full=1. With write_en_reg=0 -> write_enb=3'b000.
2. NUM_CH=3, detect_addr with data_in=3 -> next cycle addr_err=1, write_enb=0 even with write_en_reg=1, fifo_full=0. Then detect_addr with data_in=2 -> addr_err=0, write_enb=3'b100.
3. empty[0]=0, read_en[0]=0 held 65 cycles -> soft_reset[0] high only in cycles 31 and 61, timeout_sticky[0]=1 from cycle 31, vld_out[0]=1 throughout. Channels 1/2 (empty=1) stay 0.
4. Stall channel 1 and assert read_en[1] in cycle 29 -> no pulse in cycle 31. The next pulse comes 30 stalled cycles after the read.
5. Stall channel 2 for 20 cycles, then empty[2]=1 for 1 cycle, then stall again -> pulse arrives 30 cycles after the empty cycle, not 10. Also assert reset at stall cycle 25 on another run -> no pulse.
6. soft_reset[0] pulse coinciding with timeout_clr[0]=1 -> timeout_sticky[0]=1. timeout_clr[0]=1 a cycle later -> timeout_sticky[0]=0.
